// File: rtl/atm_db_arbiter_if.sv
// ---------------------------------------------------------------------------
// atm_db_arbiter_if
//   Bundle of the arbitration signals between the ATM terminal controllers and
//   the account-database arbiter.
//   Signals:
//     req       terminal -> arbiter  per-terminal access request (level)
//     rel       terminal -> arbiter  per-terminal release pulse
//     gnt       arbiter  -> terminal one-hot grant
//     gnt_id    arbiter  -> terminal index of the current owner
//     gnt_valid arbiter  -> terminal a grant is active
//     db_busy   arbiter  -> terminal database owned or in turnaround
//     timeout   arbiter  -> terminal one-cycle forced-release pulse
//   Modports: master = terminal side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface atm_db_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] rel;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;
  logic               db_busy;
  logic               timeout;

  modport master (
    output req, rel,
    input  gnt, gnt_id, gnt_valid, db_busy, timeout
  );

  modport slave (
    input  req, rel,
    output gnt, gnt_id, gnt_valid, db_busy, timeout
  );
endinterface

// File: rtl/atm_db_arbiter.sv
// ---------------------------------------------------------------------------
// atm_db_arbiter
//   Round-robin arbiter sharing the ATM account database among NUM_REQ
//   terminal controllers. A terminal keeps exclusive ownership from grant
//   until it releases (rel pulse or dropping req), which makes its balance
//   read-modify-write atomic. Each ownership is followed by one RELEASE
//   turnaround cycle and one IDLE cycle before the next grant.
//   Ports:
//     clk_i   clock, rising edge
//     rst_ni  asynchronous active-low reset
//     bus     atm_db_arbiter_if.slave (req/rel in; gnt, gnt_id, gnt_valid,
//             db_busy, timeout out)
//   Optional feature (macro ATM_ARB_TIMEOUT_EN): an owner holding the grant
//   for HOLD_MAX cycles is forcibly released, pulses timeout and is masked
//   until it drops req. Without the macro the grant is held indefinitely and
//   timeout is constant 0.
// ---------------------------------------------------------------------------
module atm_db_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int CNT_W    = 8,
  parameter int HOLD_MAX = 200
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  atm_db_arbiter_if.slave bus
);

  // Elaboration-time parameter sanity checks
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("atm_db_arbiter: NUM_REQ must be 2..8");
  end
  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("atm_db_arbiter: ID_W must equal clog2(NUM_REQ)");
  end
  if (HOLD_MAX < 1 || HOLD_MAX >= (1 << CNT_W)) begin : g_bad_hold
    $error("atm_db_arbiter: HOLD_MAX must satisfy 1 <= HOLD_MAX < 2**CNT_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic [ID_W-1:0]    ptr_q;
  logic               timeout_q;

  logic [NUM_REQ-1:0] elig_s;
  logic [ID_W:0]      pick_s;
  logic [NUM_REQ-1:0] win_oh_s;
  logic               owner_rel_s;

`ifdef ATM_ARB_TIMEOUT_EN
  logic [NUM_REQ-1:0] mask_q;
  logic [CNT_W-1:0]   hold_cnt_q;
`else
  logic [NUM_REQ-1:0] mask_s;
  assign mask_s = {NUM_REQ{1'b0}};
`endif

  // Round-robin pick: returns {found, index} of the first eligible bit after ptr.
  // The scan runs from the farthest position to the nearest so the nearest
  // eligible requester is written last and wins.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int            idx;
    res = {(ID_W+1){1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (elig[idx]) begin
        res = {1'b1, ID_W'(idx)};
      end
    end
    return res;
  endfunction

`ifdef ATM_ARB_TIMEOUT_EN
  assign elig_s = bus.req & ~mask_q;
`else
  assign elig_s = bus.req & ~mask_s;
`endif

  assign pick_s   = rr_pick(elig_s, ptr_q);
  assign win_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s[ID_W-1:0];

  // Dropping req counts as a release; rel and req falling together is one release.
  assign owner_rel_s = bus.rel[gnt_id_q] | ~bus.req[gnt_id_q];

  // Arbitration FSM with registered grant, owner index, pointer and timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gnt_q      <= {NUM_REQ{1'b0}};
      gnt_id_q   <= {ID_W{1'b0}};
      ptr_q      <= ID_W'(NUM_REQ - 1);
      timeout_q  <= 1'b0;
`ifdef ATM_ARB_TIMEOUT_EN
      mask_q     <= {NUM_REQ{1'b0}};
      hold_cnt_q <= {CNT_W{1'b0}};
`endif
    end else begin
      timeout_q <= 1'b0;
`ifdef ATM_ARB_TIMEOUT_EN
      // A masked terminal becomes eligible again once it has dropped req.
      mask_q <= mask_q & bus.req;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_s[ID_W]) begin
            gnt_q    <= win_oh_s;
            gnt_id_q <= pick_s[ID_W-1:0];
            state_q  <= ST_GRANT;
`ifdef ATM_ARB_TIMEOUT_EN
            hold_cnt_q <= {CNT_W{1'b0}};
`endif
          end else begin
            gnt_q <= {NUM_REQ{1'b0}};
          end
        end
        ST_GRANT: begin
          if (owner_rel_s) begin
            gnt_q   <= {NUM_REQ{1'b0}};
            ptr_q   <= gnt_id_q;
            state_q <= ST_RELEASE;
`ifdef ATM_ARB_TIMEOUT_EN
          end else if (hold_cnt_q == CNT_W'(HOLD_MAX - 1)) begin
            // Forced release: normal release above has priority on the same edge.
            gnt_q     <= {NUM_REQ{1'b0}};
            ptr_q     <= gnt_id_q;
            timeout_q <= 1'b1;
            mask_q    <= (mask_q & bus.req) | gnt_q;
            state_q   <= ST_RELEASE;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
`else
          end else begin
            gnt_q <= gnt_q;
`endif
          end
        end
        ST_RELEASE: begin
          gnt_q   <= {NUM_REQ{1'b0}};
          state_q <= ST_IDLE;
        end
        default: begin
          gnt_q   <= {NUM_REQ{1'b0}};
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.db_busy   = (state_q != ST_IDLE);
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_atm_db_arbiter.sv
// ---------------------------------------------------------------------------
// tb_atm_db_arbiter
//   Self-checking bench for atm_db_arbiter: a vector table for single-cycle
//   behaviour plus hand-written sequences for reset, rotation and (with
//   ATM_ARB_TIMEOUT_EN) the hold-time limit. Expected outputs go into a
//   scoreboard queue when inputs are driven and are popped after the edge.
// ---------------------------------------------------------------------------
module tb_atm_db_arbiter;

`ifdef ATM_ARB_TIMEOUT_EN
  localparam int HOLD_TB = 5;
`else
  localparam int HOLD_TB = 200;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  atm_db_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  atm_db_arbiter #(
    .NUM_REQ (4),
    .ID_W    (2),
    .CNT_W   (8),
    .HOLD_MAX(HOLD_TB)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       busy;
    logic       to;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[19];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic cmp(string name, logic [7:0] act, logic [7:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, expv);
  endtask

  function automatic exp_t mk(logic [3:0] g, logic [1:0] id, logic v, logic b, logic t);
    exp_t e;
    e.gnt = g; e.id = id; e.valid = v; e.busy = b; e.to = t;
    return e;
  endfunction

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic compare_out(string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb_q.pop_front();
    cmp(name, {1'b0, bus.gnt, bus.gnt_valid, bus.db_busy, bus.timeout},
              {1'b0, e.gnt, e.valid, e.busy, e.to});
    if (e.valid) cmp({name, "_id"}, {6'b0, bus.gnt_id}, {6'b0, e.id});
  endtask

  // Drive one cycle of inputs, queue its expectation, check after the edge.
  task automatic step(string name, logic [3:0] r, logic [3:0] l, exp_t e);
    @(negedge clk);
    bus.req = r;
    bus.rel = l;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ptr_m;
    int own;

    // req, rel, {gnt, id, valid, busy, timeout}
    vecs[0]  = '{4'b0001, 4'b0000, '{4'b0001, 2'd0, 1'b1, 1'b1, 1'b0}};
    vecs[1]  = '{4'b0001, 4'b0001, '{4'b0000, 2'd0, 1'b0, 1'b1, 1'b0}};
    vecs[2]  = '{4'b0000, 4'b0000, '{4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{4'b0000, 4'b0000, '{4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}};
    vecs[4]  = '{4'b0011, 4'b0000, '{4'b0010, 2'd1, 1'b1, 1'b1, 1'b0}};
    vecs[5]  = '{4'b0001, 4'b0000, '{4'b0000, 2'd0, 1'b0, 1'b1, 1'b0}};
    vecs[6]  = '{4'b0001, 4'b0000, '{4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{4'b0001, 4'b0000, '{4'b0001, 2'd0, 1'b1, 1'b1, 1'b0}};
    vecs[8]  = '{4'b0001, 4'b0001, '{4'b0000, 2'd0, 1'b0, 1'b1, 1'b0}};
    vecs[9]  = '{4'b0100, 4'b0000, '{4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{4'b0100, 4'b0000, '{4'b0100, 2'd2, 1'b1, 1'b1, 1'b0}};
    vecs[11] = '{4'b1110, 4'b0000, '{4'b0100, 2'd2, 1'b1, 1'b1, 1'b0}};
    vecs[12] = '{4'b0110, 4'b0010, '{4'b0100, 2'd2, 1'b1, 1'b1, 1'b0}};
    vecs[13] = '{4'b0110, 4'b0100, '{4'b0000, 2'd0, 1'b0, 1'b1, 1'b0}};
    vecs[14] = '{4'b0110, 4'b0000, '{4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}};
    vecs[15] = '{4'b0110, 4'b0000, '{4'b0010, 2'd1, 1'b1, 1'b1, 1'b0}};
    vecs[16] = '{4'b0000, 4'b0010, '{4'b0000, 2'd0, 1'b0, 1'b1, 1'b0}};
    vecs[17] = '{4'b0000, 4'b1111, '{4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}};
    vecs[18] = '{4'b0000, 4'b1111, '{4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}};

    // Reset state
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    bus.rel = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    compare_out("reset");
    cmp("reset_id", {6'b0, bus.gnt_id}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single grant/release, non-owner noise, req-drop release, idle rel
    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].rel, vecs[i].e);
    end

    // Asynchronous reset while owner 3 holds the grant
    step("rst_pre", 4'b1000, 4'b0000, mk(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0));
    #2;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    #1;
    cmp("rst_async", {5'b0, bus.gnt_valid, bus.db_busy, 1'b0} | {bus.gnt, 4'b0000},
                     8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_regrant", 4'b1000, 4'b0000, mk(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0));
    step("rst_rel",     4'b1000, 4'b1000, mk(4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
    step("rst_idle",    4'b1111, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));

    // Rotation with all requests held; model tracks the pointer
    ptr_m = 3;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      own = (ptr_m + 1) % 4;
      oh  = 4'b0001 << own;
      step($sformatf("rr%0d_gnt", g),   4'b1111, 4'b0000, mk(oh, 2'(own), 1'b1, 1'b1, 1'b0));
      step($sformatf("rr%0d_hold1", g), 4'b1111, 4'b0000, mk(oh, 2'(own), 1'b1, 1'b1, 1'b0));
      step($sformatf("rr%0d_hold2", g), 4'b1111, 4'b0000, mk(oh, 2'(own), 1'b1, 1'b1, 1'b0));
      step($sformatf("rr%0d_rel", g),   4'b1111, oh,      mk(4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
      step($sformatf("rr%0d_gap", g),   4'b1111, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
      ptr_m = own;
    end
    step("rr_end", 4'b0000, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));

`ifdef ATM_ARB_TIMEOUT_EN
    // Forced release after HOLD_MAX cycles, then masking until req toggles
    step("to_gnt", 4'b0010, 4'b0000, mk(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0));
    for (int h = 0; h < HOLD_TB - 1; h++)
      step($sformatf("to_hold%0d", h), 4'b0010, 4'b0000, mk(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0));
    step("to_force",   4'b0010, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b1, 1'b1));
    step("to_masked1", 4'b0010, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    step("to_masked2", 4'b0010, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    step("to_drop",    4'b0000, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    step("to_regrant", 4'b0010, 4'b0000, mk(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0));
    for (int h = 0; h < HOLD_TB - 1; h++)
      step($sformatf("to2_hold%0d", h), 4'b0010, 4'b0000, mk(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0));
    // Normal release on the limit edge wins: no timeout pulse
    step("to_relwin",  4'b0010, 4'b0010, mk(4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
    step("to_idle",    4'b0000, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
